// File: rtl/simple_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : simple_mem_pkg
// Purpose  : Shared types and default constants for the simple_mem_resp
//            memory responder (FSM state encoding, default widths, maximum
//            supported read latency).
// Ports    : n/a (package)
// Revision : 1.0 - initial release
// ============================================================================
package simple_mem_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 8;
    localparam int READ_LAT_MAX = 4;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage : simple_mem_pkg
`default_nettype wire

// File: rtl/mem_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mem_rd_pipe
// Purpose  : READ_LAT-deep data + valid delay line for read responses.
//            A data stage only loads when a valid word arrives, so the
//            output data holds its last read result between valid pulses.
// Ports    : clk, rst (async, active-high)
//            in_valid / in_data   - read result sampled at the current edge
//            out_valid / out_data - result after READ_LAT-1 further edges
// Revision : 1.0 - initial release
// ============================================================================
module mem_rd_pipe
    import simple_mem_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    // Out-of-range latencies are clamped into the supported 1..READ_LAT_MAX.
    localparam int LAT = (READ_LAT < 1) ? 1 :
                         (READ_LAT > READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT;

    logic [LAT-1:0]    valid_q, valid_d;
    logic [DATA_W-1:0] data_q [LAT];
    logic [DATA_W-1:0] data_d [LAT];

    always_comb begin
        valid_d    = {valid_q[LAT-1:0], in_valid} >> 0;
        valid_d[0] = in_valid;
        data_d     = data_q;
        if (in_valid) begin
            data_d[0] = in_data;
        end
        for (int i = 1; i < LAT; i++) begin
            valid_d[i] = valid_q[i-1];
            if (valid_q[i-1]) begin
                data_d[i] = data_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q[LAT-1];
    assign out_data  = data_q[LAT-1];

endmodule : mem_rd_pipe
`default_nettype wire

// File: rtl/simple_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : simple_mem_resp
// Purpose  : Memory-side responder for the simple_proc data bus. After reset
//            it writes INIT_VAL to every word (busy=1), then serves
//            writes (we=1) and reads (we=0) every edge. Reads return through
//            a READ_LAT-deep registered pipe. Out-of-range accesses set a
//            sticky err; writes/reads are counted with saturating counters.
// Ports    : clk, rst (async, active-high)
//            we, address, wdata      - processor bus inputs
//            rdata, rd_valid         - read response
//            busy                    - clear sequence in progress
//            err                     - sticky out-of-range flag
//            wr_cnt, rd_cnt          - saturating access counters
// Revision : 1.0 - initial release
// ============================================================================
module simple_mem_resp
    import simple_mem_pkg::*;
#(
    parameter int                 DATA_W    = DEF_DATA_W,
    parameter int                 ADDR_W    = DEF_ADDR_W,
    parameter int                 MEM_DEPTH = 256,
    parameter int                 READ_LAT  = 1,
    parameter logic [DATA_W-1:0]  INIT_VAL  = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rd_valid,
    output logic              busy,
    output logic              err,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  rd_cnt
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    logic              in_range;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_widx;
    logic [DATA_W-1:0] mem_wdata;
    logic              rd_req;
    logic [DATA_W-1:0] rd_word;

    // Extra MSB so MEM_DEPTH == 2**ADDR_W compares correctly.
    assign in_range = ({1'b0, address} < (ADDR_W+1)'(MEM_DEPTH));

    // Out-of-range reads return zero instead of touching the array.
    assign rd_word  = in_range ? mem_q[address[IDX_W-1:0]] : '0;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        err_d     = err_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        mem_we    = 1'b0;
        mem_widx  = address[IDX_W-1:0];
        mem_wdata = wdata;
        rd_req    = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                // Bus is ignored here; the array port belongs to the clear.
                mem_we    = 1'b1;
                mem_widx  = clr_idx_q[IDX_W-1:0];
                mem_wdata = INIT_VAL;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == ADDR_W'(MEM_DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (we) begin
                    mem_we = in_range;
                    if (!(&wr_cnt_q)) begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end else begin
                    rd_req = 1'b1;
                    if (!(&rd_cnt_q)) begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
                if (!in_range) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
            err_q     <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            err_q     <= err_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
        end
    end

    // Storage has no reset: its contents are re-initialised by the clear.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_widx] <= mem_wdata;
        end
    end

    mem_rd_pipe #(
        .DATA_W   (DATA_W),
        .READ_LAT (READ_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_req),
        .in_data   (rd_word),
        .out_valid (rd_valid),
        .out_data  (rdata)
    );

    assign busy   = (state_q == ST_CLEAR);
    assign err    = err_q;
    assign wr_cnt = wr_cnt_q;
    assign rd_cnt = rd_cnt_q;

endmodule : simple_mem_resp
`default_nettype wire

// File: tb/tb_simple_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_simple_mem_resp
// Purpose  : Self-checking bench for simple_mem_resp (MEM_DEPTH=200,
//            READ_LAT=3, CNT_W=4, non-zero INIT_VAL). Directed table,
//            hand-written corner sequences and random traffic, all compared
//            against a behavioural model of the memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simple_mem_resp;

    localparam int          DW    = 32;
    localparam int          AW    = 8;
    localparam int          DEPTH = 200;
    localparam int          LAT   = 3;
    localparam int          CW    = 4;
    localparam logic [31:0] INIT  = 32'h5A5A_0001;
    localparam int          CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    logic [AW-1:0] address;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          rd_valid;
    logic          busy;
    logic          err;
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] rd_cnt;

    simple_mem_resp #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .MEM_DEPTH (DEPTH),
        .READ_LAT  (LAT),
        .INIT_VAL  (INIT),
        .CNT_W     (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .address  (address),
        .wdata    (wdata),
        .rdata    (rdata),
        .rd_valid (rd_valid),
        .busy     (busy),
        .err      (err),
        .wr_cnt   (wr_cnt),
        .rd_cnt   (rd_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int due; logic [31:0] d; } pend_t;

    logic [31:0] m_mem [256];
    int          m_clear_edges;
    bit          m_err;
    int          m_wr, m_rd;
    bit          m_rvalid;
    logic [31:0] m_rdata;
    int          m_cyc;
    pend_t       m_pend [$];

    // After reset the memory is, as seen from the bus, all INIT words.
    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_mem[i] = INIT;
        m_clear_edges = 0;
        m_err = 0; m_wr = 0; m_rd = 0;
        m_rvalid = 0; m_rdata = '0;
        m_pend.delete();
    endtask

    task automatic model_edge(input bit w, input logic [7:0] a, input logic [31:0] d);
        m_cyc++;
        if (m_clear_edges < DEPTH) begin
            m_clear_edges++;
        end else if (w) begin
            if (a < DEPTH) m_mem[a] = d; else m_err = 1;
            if (m_wr < CMAX) m_wr++;
        end else begin
            m_pend.push_back('{m_cyc + LAT - 1, (a < DEPTH) ? m_mem[a] : 32'h0});
            if (a < DEPTH == 0) m_err = 1;
            if (m_rd < CMAX) m_rd++;
        end
        m_rvalid = 0;
        if (m_pend.size() > 0 && m_pend[0].due == m_cyc) begin
            m_rvalid = 1;
            m_rdata  = m_pend[0].d;
            void'(m_pend.pop_front());
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".busy"},     32'(busy),     32'(m_clear_edges < DEPTH));
        chk({tag, ".err"},      32'(err),      32'(m_err));
        chk({tag, ".wr_cnt"},   32'(wr_cnt),   32'(m_wr));
        chk({tag, ".rd_cnt"},   32'(rd_cnt),   32'(m_rd));
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(m_rvalid));
        chk({tag, ".rdata"},    rdata,         m_rdata);
    endtask

    // Called at posedge+1: drive, take one edge, update model, compare.
    task automatic step(input bit w, input logic [7:0] a, input logic [31:0] d);
        we = w; address = a; wdata = d;
        @(posedge clk);
        model_edge(w, a, d);
        #1;
        check_all("step");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_all("rst_async");
        repeat (2) begin
            @(posedge clk);
            #1;
            check_all("rst_hold");
        end
        rst = 1'b0;
    endtask

    task automatic run_clear(input bit w);
        for (int i = 0; i < DEPTH; i++) step(w, 8'($urandom), $urandom);
        chk("clear_busy_done", 32'(busy), 32'h0);
        chk("clear_wr_cnt", 32'(wr_cnt), 32'h0);
        chk("clear_rd_cnt", 32'(rd_cnt), 32'h0);
    endtask

    typedef struct {
        bit          w;
        logic [7:0]  a;
        logic [31:0] d;
        bit          ev;
        logic [31:0] er;
        bit          ee;
    } vec_t;

    vec_t tbl [17];

    initial begin
        // Expected rd_valid/rdata/err after each edge (read shows LAT-1 edges later).
        tbl[0]  = '{1'b1, 8'h12, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 8'h12, 32'h0,        1'b0, 32'h0,        1'b0};
        tbl[2]  = '{1'b0, 8'h05, 32'h0,        1'b0, 32'h0,        1'b0};
        tbl[3]  = '{1'b1, 8'h01, 32'hA,        1'b1, 32'hDEADBEEF, 1'b0};
        tbl[4]  = '{1'b1, 8'h02, 32'hB,        1'b1, INIT,         1'b0};
        tbl[5]  = '{1'b1, 8'h03, 32'hC,        1'b0, INIT,         1'b0};
        tbl[6]  = '{1'b0, 8'h01, 32'h0,        1'b0, INIT,         1'b0};
        tbl[7]  = '{1'b0, 8'h02, 32'h0,        1'b0, INIT,         1'b0};
        tbl[8]  = '{1'b0, 8'h03, 32'h0,        1'b1, 32'hA,        1'b0};
        tbl[9]  = '{1'b1, 8'd210, 32'h55,      1'b1, 32'hB,        1'b1};
        tbl[10] = '{1'b0, 8'd210, 32'h0,       1'b1, 32'hC,        1'b1};
        tbl[11] = '{1'b1, 8'h12, 32'h1,        1'b0, 32'hC,        1'b1};
        tbl[12] = '{1'b0, 8'h00, 32'h0,        1'b1, 32'h0,        1'b1};
        tbl[13] = '{1'b0, 8'h12, 32'h0,        1'b0, 32'h0,        1'b1};
        tbl[14] = '{1'b1, 8'h00, 32'h7,        1'b1, INIT,         1'b1};
        tbl[15] = '{1'b1, 8'h00, 32'h8,        1'b1, 32'h1,        1'b1};
        tbl[16] = '{1'b1, 8'h00, 32'h9,        1'b0, 32'h1,        1'b1};

        m_cyc = 0;
        rst = 1'b1; we = 1'b0; address = '0; wdata = '0;
        model_reset();
        #1;
        check_all("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Clear with write traffic on the bus: must be ignored.
        run_clear(1'b1);

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].w, tbl[i].a, tbl[i].d);
            chk($sformatf("tbl%0d.rd_valid", i), 32'(rd_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d.rdata", i),    rdata,         tbl[i].er);
            chk($sformatf("tbl%0d.err", i),      32'(err),      32'(tbl[i].ee));
        end

        // Reset two cycles after a read: the read must never surface.
        step(1'b1, 8'h40, 32'h1234_5678);
        step(1'b0, 8'h40, 32'h0);
        step(1'b1, 8'h40, 32'h1234_5678);
        do_reset();
        chk("midrd_busy", 32'(busy), 32'h1);
        run_clear(1'b0);
        step(1'b0, 8'h40, 32'h0);
        step(1'b0, 8'h41, 32'h0);
        step(1'b0, 8'h42, 32'h0);
        chk("reclear_valid", 32'(rd_valid), 32'h1);
        chk("reclear_rdata", rdata, INIT);
        chk("reclear_err", 32'(err), 32'h0);

        // Counter saturation.
        for (int i = 0; i < 20; i++) step(1'b1, 8'h07, 32'(i));
        chk("wr_cnt_sat", 32'(wr_cnt), 32'd15);

        // Random traffic with one reset in the middle.
        for (int i = 0; i < 300; i++) begin
            logic [7:0] a;
            if (i == 150) begin
                do_reset();
                run_clear($urandom_range(0, 1) == 1);
            end
            if ($urandom_range(0, 9) == 0) a = 8'($urandom_range(DEPTH, 255));
            else                           a = 8'($urandom_range(0, 15));
            step($urandom_range(0, 1) == 1, a, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_simple_mem_resp
`default_nettype wire
